// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display paths: pixel-format codes,
// stock 640x480@60 timing and frame-total helpers.
package vga_pkg;

    localparam int FMT_RGB332 = 0;
    localparam int FMT_GRAY8  = 1;
    localparam int FMT_RGB444 = 2;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // Per-pixel control flags travelling alongside the RAM read.
    typedef struct packed {
        logic first;
        logic act;
        logic vs;
        logic hs;
    } scan_flags_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pix_fmt.sv
// Registered formatter from a framebuffer word to 4:4:4 RGB; blanks to
// zero whenever display enable is low.
module vga_pix_fmt
    import vga_pkg::*;
#(
    parameter int FMT    = FMT_RGB332,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [3:0]        r_o,
    output logic [3:0]        g_o,
    output logic [3:0]        b_o
);

    logic [11:0] d;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;

    // Narrow channels are widened by repeating their top bits so full scale maps to 0xF.
    always_comb begin
        d     = 12'(data_i);
        rgb_d = '0;
        if (de_i) begin
            case (FMT)
                FMT_GRAY8:  rgb_d = {d[7:4], d[7:4], d[7:4]};
                FMT_RGB444: rgb_d = d;
                default:    rgb_d = {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign {r_o, g_o, b_o} = rgb_q;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan engine: sync timing, scaled framebuffer address walk with
// frame-boundary buffer swap, and latency-matched pixel output.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int SCALE    = 1,
    parameter int FMT      = FMT_RGB332,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_data,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              de,
    output logic              frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] REP_LAST = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SRC_STEP = ADDR_W'(H_ACTIVE / SCALE);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [SW-1:0]     x_rep_q, x_rep_d;
    logic [SW-1:0]     y_rep_q, y_rep_d;
    logic [ADDR_W-1:0] x_src_q, x_src_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] active_base_q, active_base_d;
    logic [ADDR_W-1:0] pending_base_q, pending_base_d;
    logic              pending_valid_q, pending_valid_d;
    logic              swap_ack_q, swap_ack_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    scan_flags_t [RD_LAT:0] flag_pipe_q, flag_pipe_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              de_q, de_d;
    logic              frame_start_q, frame_start_d;

    logic        h_last, v_last, frame_wrap, line_active, active;
    scan_flags_t flags0;
    scan_flags_t tail;

    always_comb begin
        h_last      = (h_cnt_q == H_LAST);
        v_last      = (v_cnt_q == V_LAST);
        frame_wrap  = h_last && v_last;
        line_active = (v_cnt_q < V_ACT);
        active      = (h_cnt_q < H_ACT) && line_active;

        flags0.hs    = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        flags0.vs    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
        flags0.act   = active;
        flags0.first = active && (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end

        // Source x/y step once every SCALE output pixels/lines, so no multiply is needed.
        x_rep_d     = x_rep_q;
        x_src_d     = x_src_q;
        y_rep_d     = y_rep_q;
        line_base_d = line_base_q;
        if (active) begin
            if (x_rep_q == REP_LAST) begin
                x_rep_d = '0;
                x_src_d = x_src_q + ADDR_ONE;
            end else begin
                x_rep_d = x_rep_q + SW'(1);
            end
        end
        if (h_last) begin
            x_rep_d = '0;
            x_src_d = '0;
            if (line_active) begin
                if (y_rep_q == REP_LAST) begin
                    y_rep_d     = '0;
                    line_base_d = line_base_q + SRC_STEP;
                end else begin
                    y_rep_d = y_rep_q + SW'(1);
                end
            end
        end
        if (frame_wrap) begin
            y_rep_d     = '0;
            line_base_d = '0;
        end

        fb_addr_d = active_base_q + line_base_q + x_src_q;

        // swap_req is a one-cycle capture strobe (no back-pressure); swap_ack
        // pulses once when the captured base goes live at a frame boundary.
        active_base_d   = active_base_q;
        pending_base_d  = pending_base_q;
        pending_valid_d = pending_valid_q;
        swap_ack_d      = 1'b0;
        if (frame_wrap && pending_valid_q) begin
            active_base_d   = pending_base_q;
            pending_valid_d = 1'b0;
            swap_ack_d      = 1'b1;
        end
        if (swap_req) begin
            pending_base_d  = fb_base;
            pending_valid_d = 1'b1;
        end

        flag_pipe_d   = {flag_pipe_q[RD_LAT-1:0], flags0};
        tail          = flag_pipe_q[RD_LAT];
        hsync_d       = tail.hs ? HS_ON : ~HS_ON;
        vsync_d       = tail.vs ? VS_ON : ~VS_ON;
        de_d          = tail.act;
        frame_start_d = tail.first;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q         <= '0;
            v_cnt_q         <= '0;
            x_rep_q         <= '0;
            y_rep_q         <= '0;
            x_src_q         <= '0;
            line_base_q     <= '0;
            active_base_q   <= '0;
            pending_base_q  <= '0;
            pending_valid_q <= 1'b0;
            swap_ack_q      <= 1'b0;
            fb_addr_q       <= '0;
            flag_pipe_q     <= '0;
            hsync_q         <= ~HS_ON;
            vsync_q         <= ~VS_ON;
            de_q            <= 1'b0;
            frame_start_q   <= 1'b0;
        end else begin
            h_cnt_q         <= h_cnt_d;
            v_cnt_q         <= v_cnt_d;
            x_rep_q         <= x_rep_d;
            y_rep_q         <= y_rep_d;
            x_src_q         <= x_src_d;
            line_base_q     <= line_base_d;
            active_base_q   <= active_base_d;
            pending_base_q  <= pending_base_d;
            pending_valid_q <= pending_valid_d;
            swap_ack_q      <= swap_ack_d;
            fb_addr_q       <= fb_addr_d;
            flag_pipe_q     <= flag_pipe_d;
            hsync_q         <= hsync_d;
            vsync_q         <= vsync_d;
            de_q            <= de_d;
            frame_start_q   <= frame_start_d;
        end
    end

    // The tail of the flag pipe lines up with fb_data, so RGB and syncs leave on the same edge.
    vga_pix_fmt #(
        .FMT    (FMT),
        .DATA_W (DATA_W)
    ) u_pix_fmt (
        .clk    (clk),
        .rst    (rst),
        .de_i   (flag_pipe_q[RD_LAT].act),
        .data_i (fb_data),
        .r_o    (vga_r),
        .g_o    (vga_g),
        .b_o    (vga_b)
    );

    assign fb_rd_en    = flag_pipe_q[0].act;
    assign fb_addr     = fb_addr_q;
    assign swap_ack    = swap_ack_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;

endmodule
